divisor_arbitro: RTL and testbench

//  Round-robin scheduler sharing one signed iterative divider (Start/Done, Num/Den -> Coc/Res)

---
 rtl/divisor_arbitro.sv | 174 +++++++++++++++++
 tb/tb_divisor_arbitro.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_arbitro.sv
// rtl/divisor_arbitro.sv - round-robin scheduler sharing one signed iterative divider among NREQ requesters
module divisor_arbitro #(
    parameter int tamanyo = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                      CLK,
    input  logic                      RSTa,
    input  logic [NREQ-1:0]           Req,
    input  logic [NREQ*tamanyo-1:0]   Num_bus,
    input  logic [NREQ*tamanyo-1:0]   Den_bus,
    output logic [NREQ-1:0]           Ack,
    output logic [tamanyo-1:0]        Coc,
    output logic [tamanyo-1:0]        Res,
    output logic                      Err,
    output logic                      Busy,
    output logic                      Div_Start,
    output logic [tamanyo-1:0]        Div_Num,
    output logic [tamanyo-1:0]        Div_Den,
    output logic                      Div_RSTa,
    input  logic [tamanyo-1:0]        Div_Coc,
    input  logic [tamanyo-1:0]        Div_Res,
    input  logic                      Div_Done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RECOVER,
        S_DELIVER
    } state_t;

    state_t              state, state_d;
    logic [IW-1:0]       ptr, ptr_d;
    logic [IW-1:0]       grant, grant_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic                just_served, just_served_d;
    logic [NREQ-1:0]     ack_d;
    logic [tamanyo-1:0]  coc_d, res_d, num_d, den_d;
    logic                err_d, busy_d, start_d, drsta_d;

    logic [NREQ-1:0]     served_mask, elig;
    logic                found;
    logic [IW-1:0]       pick;
    logic [tamanyo-1:0]  sel_num, sel_den;
    int                  idx;

    always_comb begin
        state_d       = state;
        ptr_d         = ptr;
        grant_d       = grant;
        cnt_d         = cnt;
        coc_d         = Coc;
        res_d         = Res;
        err_d         = Err;
        num_d         = Div_Num;
        den_d         = Div_Den;
        served_mask   = '0;
        found         = 1'b0;
        pick          = '0;
        sel_num       = '0;
        sel_den       = '0;
        idx           = 0;

        // The requester just served gets one cycle to drop Req before it can win again.
        served_mask[grant] = just_served;
        elig = Req & ~served_mask;

        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && elig[idx]) begin
                found   = 1'b1;
                pick    = IW'(idx);
                sel_num = Num_bus[idx*tamanyo +: tamanyo];
                sel_den = Den_bus[idx*tamanyo +: tamanyo];
            end
        end

        case (state)
            S_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    num_d   = sel_num;
                    den_d   = sel_den;
                    if (sel_den == '0) begin
                        coc_d   = '0;
                        res_d   = '0;
                        err_d   = 1'b1;
                        state_d = S_DELIVER;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (Div_Done) begin
                    coc_d   = Div_Coc;
                    res_d   = Div_Res;
                    err_d   = 1'b0;
                    state_d = S_DELIVER;
                end else if (cnt == CNT_LAST) begin
                    state_d = S_RECOVER;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            S_RECOVER: begin
                coc_d   = '0;
                res_d   = '0;
                err_d   = 1'b1;
                state_d = S_DELIVER;
            end
            S_DELIVER: begin
                ptr_d   = (grant == IDX_LAST) ? '0 : grant + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are derived from the next state so every output leaves a flop.
        ack_d = '0;
        if (state_d == S_DELIVER) ack_d[grant_d] = 1'b1;
        busy_d        = (state_d != S_IDLE);
        start_d       = (state_d == S_LAUNCH);
        drsta_d       = (state_d != S_RECOVER);
        just_served_d = (state == S_DELIVER);
    end

    always_ff @(posedge CLK) begin
        if (!RSTa) begin
            state       <= S_IDLE;
            ptr         <= '0;
            grant       <= '0;
            cnt         <= '0;
            just_served <= 1'b0;
            Ack         <= '0;
            Coc         <= '0;
            Res         <= '0;
            Err         <= 1'b0;
            Busy        <= 1'b0;
            Div_Start   <= 1'b0;
            Div_Num     <= '0;
            Div_Den     <= '0;
            Div_RSTa    <= 1'b0;
        end else begin
            state       <= state_d;
            ptr         <= ptr_d;
            grant       <= grant_d;
            cnt         <= cnt_d;
            just_served <= just_served_d;
            Ack         <= ack_d;
            Coc         <= coc_d;
            Res         <= res_d;
            Err         <= err_d;
            Busy        <= busy_d;
            Div_Start   <= start_d;
            Div_Num     <= num_d;
            Div_Den     <= den_d;
            Div_RSTa    <= drsta_d;
        end
    end

endmodule

// File: tb/tb_divisor_arbitro.sv
// tb/tb_divisor_arbitro.sv - directed self-checking bench for divisor_arbitro with a behavioural divider
module tb_divisor_arbitro;

    logic         clk = 1'b0;
    logic         rsta;
    logic [3:0]   req;
    logic [127:0] num_bus, den_bus;
    logic [3:0]   ack;
    logic [31:0]  coc, res;
    logic         err, busy, div_start, div_rsta;
    logic [31:0]  div_num, div_den;
    logic [31:0]  div_coc = '0, div_res = '0;
    logic         div_done = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    divisor_arbitro #(.tamanyo(32), .NREQ(4), .TIMEOUT(20)) dut (
        .CLK(clk), .RSTa(rsta), .Req(req), .Num_bus(num_bus), .Den_bus(den_bus),
        .Ack(ack), .Coc(coc), .Res(res), .Err(err), .Busy(busy),
        .Div_Start(div_start), .Div_Num(div_num), .Div_Den(div_den), .Div_RSTa(div_rsta),
        .Div_Coc(div_coc), .Div_Res(div_res), .Div_Done(div_done)
    );

    // Divider stand-in: 5 cycles from sampling Start to raising Done; 'hang' never finishes.
    logic        hang = 1'b0;
    logic        m_busy = 1'b0;
    logic [7:0]  m_cnt = '0;
    logic [31:0] m_a = '0, m_b = '1;
    int          starts = 0;

    always @(posedge clk) begin
        div_done <= 1'b0;
        if (div_start === 1'b1) starts <= starts + 1;
        if (div_rsta !== 1'b1) begin
            m_busy <= 1'b0;
        end else if (div_start && !hang) begin
            m_busy <= 1'b1;
            m_cnt  <= 8'd5;
            m_a    <= div_num;
            m_b    <= div_den;
        end else if (m_busy) begin
            if (m_cnt == 8'd1) begin
                m_busy   <= 1'b0;
                div_done <= 1'b1;
                div_coc  <= $signed(m_a) / $signed(m_b);
                div_res  <= $signed(m_a) % $signed(m_b);
            end else begin
                m_cnt <= m_cnt - 8'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] n, input logic [31:0] d);
        num_bus[i*32 +: 32] = n;
        den_bus[i*32 +: 32] = d;
    endtask

    logic [3:0]  a_ack;
    logic [31:0] a_coc, a_res;
    logic        a_err;
    int          rst_lows, first_low;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until Ack appears; an expired bound leaves a_ack=0 for the caller's check.
    task automatic wait_ack(output int cyc);
        cyc = 0;
        rst_lows = 0;
        first_low = 0;
        while (cyc < 100 && ack == 4'b0) begin
            step();
            cyc++;
            if (!div_rsta) begin
                rst_lows++;
                if (first_low == 0) first_low = cyc;
            end
        end
        a_ack = ack;
        a_coc = coc;
        a_res = res;
        a_err = err;
    endtask

    int          cyc, s0;
    logic [3:0]  acc;
    logic [3:0]  exp_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [31:0] exp_coc [5] = '{32'd3, 32'd6, 32'd10, 32'd13, 32'd3};
    logic [31:0] exp_res [5] = '{32'd1, 32'd2, 32'd0, 32'd1, 32'd1};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rsta = 1'b0; req = '0; num_bus = '0; den_bus = '0;
        step();
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_div_rsta", 32'(div_rsta), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_coc", coc, 32'd0);
        rsta = 1'b1;
        step();
        check("rst_release_div_rsta", 32'(div_rsta), 32'd1);

        // 7 / 2 from requester 1
        s0 = starts;
        set_op(1, 32'd7, 32'd2);
        req = 4'b0010;
        wait_ack(cyc);
        check("p_ack", 32'(a_ack), 32'h2);
        check("p_coc", a_coc, 32'd3);
        check("p_res", a_res, 32'd1);
        check("p_err", 32'(a_err), 32'd0);
        check("p_latency", 32'(cyc), 32'd8);
        check("p_starts", 32'(starts - s0), 32'd1);
        check("p_div_num", div_num, 32'd7);
        step();
        step();
        check("mask_no_regrant", 32'(busy), 32'd0);
        req = '0;
        step();

        // -7 / 2 from requester 2
        set_op(2, 32'hFFFF_FFF9, 32'd2);
        req = 4'b0100;
        wait_ack(cyc);
        check("n_ack", 32'(a_ack), 32'h4);
        check("n_coc", a_coc, 32'hFFFF_FFFD);
        check("n_res", a_res, 32'hFFFF_FFFF);
        check("n_err", 32'(a_err), 32'd0);
        req = '0;
        step();
        step();

        // division by zero trapped without touching the divider
        s0 = starts;
        set_op(0, 32'd5, 32'd0);
        req = 4'b0001;
        wait_ack(cyc);
        check("z_ack", 32'(a_ack), 32'h1);
        check("z_err", 32'(a_err), 32'd1);
        check("z_coc", a_coc, 32'd0);
        check("z_res", a_res, 32'd0);
        check("z_latency", 32'(cyc), 32'd1);
        check("z_starts", 32'(starts - s0), 32'd0);
        req = '0;
        step();
        step();

        // runaway division aborted after TIMEOUT wait cycles
        hang = 1'b1;
        set_op(3, 32'h7FFF_FFFF, 32'd1);
        req = 4'b1000;
        wait_ack(cyc);
        check("t_ack", 32'(a_ack), 32'h8);
        check("t_err", 32'(a_err), 32'd1);
        check("t_coc", a_coc, 32'd0);
        check("t_latency", 32'(cyc), 32'd23);
        check("t_rsta_lows", 32'(rst_lows), 32'd1);
        check("t_rsta_when", 32'(first_low), 32'd22);
        req = '0;
        step();
        step();

        // reset while waiting on the divider
        set_op(3, 32'd9, 32'd3);
        req = 4'b1000;
        repeat (4) step();
        check("r_busy_before", 32'(busy), 32'd1);
        rsta = 1'b0;
        req = '0;
        step();
        check("r_ack", 32'(ack), 32'd0);
        check("r_busy", 32'(busy), 32'd0);
        check("r_err", 32'(err), 32'd0);
        check("r_div_start", 32'(div_start), 32'd0);
        check("r_div_num", div_num, 32'd0);
        check("r_div_rsta_low", 32'(div_rsta), 32'd0);
        rsta = 1'b1;
        step();
        check("r_div_rsta_high", 32'(div_rsta), 32'd1);
        acc = '0;
        repeat (6) begin
            step();
            acc = acc | ack;
        end
        check("r_no_ack", 32'(acc), 32'd0);
        hang = 1'b0;

        // fairness with everyone requesting
        for (int i = 0; i < 4; i++) set_op(i, 32'(10 * (i + 1)), 32'd3);
        req = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ack(cyc);
            check($sformatf("rr_ack%0d", k), 32'(a_ack), 32'(exp_ack[k]));
            check($sformatf("rr_coc%0d", k), a_coc, exp_coc[k]);
            check($sformatf("rr_res%0d", k), a_res, exp_res[k]);
            req = req & ~a_ack;
            step();
            req = 4'hF;
        end
        req = '0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
